// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   - clks_per_bit / half_bit: bit-timing helpers derived from clock and baud rate
//   - rx_state_t: receiver FSM states
//   - DATA_BITS: payload bits per 8N1 frame
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic int half_bit(input int clk_hz, input int baud);
    return clks_per_bit(clk_hz, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
// Ports:
//   clk, rst            clock, synchronous active-high reset (pointers/count only)
//   push, push_data     write request and data; ignored when full unless a pop
//                       happens in the same cycle
//   pop                 read request; ignored when empty
//   pop_data            head entry, 0 when empty
//   full, empty, count  occupancy status
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver (LSB first) feeding a byte FIFO with a
// valid/ready output stream and CTS flow control.
// Ports:
//   sys_clk    clock, all logic on rising edge
//   rst        synchronous active-high reset
//   RX         asynchronous serial input, idle high
//   CTS        1 = host may send; 0 while FIFO occupancy >= CTS_THRESH
//   rx_data    head-of-FIFO byte (show-ahead)
//   rx_valid   FIFO not empty
//   rx_ready   consumer pop, taken when rx_valid && rx_ready
//   frame_err  1-cycle pulse: stop bit sampled low
//   overflow   1-cycle pulse: completed byte dropped because FIFO full
// Build option: define UART_RX_MAJORITY_EN to take a 2-of-3 vote around every
// sample point (decision one cycle after the nominal sample count).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 200_000_000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16,
  parameter int CTS_THRESH  = 12
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       RX,
  output logic       CTS,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overflow
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int HALF_BIT     = half_bit(CLK_FREQ_HZ, BAUD);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W        = $clog2(DATA_BITS);
  localparam int CW           = $clog2(FIFO_DEPTH) + 1;

`ifdef UART_RX_MAJORITY_EN
  localparam int START_PT = HALF_BIT;
`else
  localparam int START_PT = HALF_BIT - 1;
`endif
  // Every later sample is a whole bit period after the previous decision, so
  // the one-cycle vote delay is carried forward without drift.
  localparam logic [CNT_W-1:0] START_PT_C = CNT_W'(START_PT);
  localparam logic [CNT_W-1:0] BIT_PT_C   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX_C = IDX_W'(DATA_BITS - 1);
  localparam logic [CW-1:0]    CTS_THR_C  = CW'(CTS_THRESH);

  logic                 rx_p0;
  logic                 rx_s;
  logic                 sample_bit;
  rx_state_t            state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_p1;
  logic                 vld_p2;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;

  // Stage p0/p1: two-flop synchroniser, idles high
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= RX;
      rx_s  <= rx_p0;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] rx_hist;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge sys_clk) begin
    if (rst) rx_hist <= 2'b11;
    else     rx_hist <= {rx_hist[0], rx_s};
  end

  // Votes over the samples at decision-2, decision-1 and decision.
  assign sample_bit = majority3(rx_s, rx_hist[0], rx_hist[1]);
`else
  assign sample_bit = rx_s;
`endif

  // Stage p1: bit timing and frame FSM
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      vld_p2    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      vld_p2    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (bit_cnt == START_PT_C) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            // A line back high at mid start bit is a glitch, not a frame.
            state   <= sample_bit ? IDLE : DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_cnt == BIT_PT_C) begin
            bit_cnt <= '0;
            if (bit_idx == LAST_IDX_C) state <= STOP;
            else                       bit_idx <= bit_idx + 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_cnt == BIT_PT_C) begin
            bit_cnt <= '0;
            if (sample_bit) begin
              vld_p2 <= 1'b1;
              state  <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        BREAK: begin
          // Hold off start detection until the line has returned high.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (state == DATA && bit_cnt == BIT_PT_C) shift_p1[bit_idx] <= sample_bit;
  end

  // Stage p2: completed byte enters the FIFO
  sync_fifo #(
    .DATA_W (DATA_BITS),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (sys_clk),
    .rst       (rst),
    .push      (vld_p2),
    .push_data (shift_p1),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rx_valid = !fifo_empty;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      CTS      <= 1'b1;
      overflow <= 1'b0;
    end else begin
      CTS      <= (fifo_count < CTS_THR_C);
      overflow <= vld_p2 && fifo_full && !(rx_valid && rx_ready);
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a byte scoreboard. The baud rate is
// raised so that one bit lasts 16 clocks, keeping whole-frame runs short.
module tb_uart_rx_fifo;

  localparam int CLK_FREQ_HZ = 200_000_000;
  localparam int BAUD        = 12_500_000;
  localparam int CPB         = CLK_FREQ_HZ / BAUD;
  localparam int FIFO_DEPTH  = 16;
  localparam int CTS_THRESH  = 12;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       RX = 1'b1;
  logic       rx_ready = 1'b0;
  logic       CTS;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overflow;

  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int valid_cycles  = 0;
  int frame_err_cnt = 0;
  int overflow_cnt  = 0;

  uart_rx_fifo #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD        (BAUD),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .CTS_THRESH  (CTS_THRESH)
  ) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .RX        (RX),
    .CTS       (CTS),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every accepted pop is compared against the oldest expected byte.
  always @(negedge sys_clk) begin
    if (!rst) begin
      if (rx_valid)  valid_cycles++;
      if (frame_err) frame_err_cnt++;
      if (overflow)  overflow_cnt++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_size_at_pop", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_exp = exp_q.pop_front();
          check("rx_data", {24'd0, rx_data}, {24'd0, mon_exp});
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge sys_clk);
    RX = 1'b0;
    repeat (CPB) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge sys_clk);
    end
    RX = stop_bit;
    repeat (CPB) @(negedge sys_clk);
    RX = 1'b1;
    repeat (4) @(negedge sys_clk);
  endtask

  // Same frame, but each data bit carries a one-clock inverted spike mid-bit.
  task automatic send_frame_spiked(input logic [7:0] b);
    @(negedge sys_clk);
    RX = 1'b0;
    repeat (CPB) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < CPB; j++) begin
        RX = (j == CPB / 2) ? ~b[i] : b[i];
        @(negedge sys_clk);
      end
    end
    RX = 1'b1;
    repeat (CPB + 4) @(negedge sys_clk);
  endtask

  task automatic drain(input string tag);
    rx_ready = 1'b1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge sys_clk);
    repeat (2) @(negedge sys_clk);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    int fe_before;
    int ov_before;

    // Reset state
    rst = 1'b1;
    RX = 1'b1;
    rx_ready = 1'b0;
    repeat (4) @(negedge sys_clk);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_cts", {31'd0, CTS}, 32'd1);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge sys_clk);

    // Single byte 0x2A, consumer always ready: one-cycle valid
    rx_ready = 1'b1;
    valid_cycles = 0;
    exp_q.push_back(8'h2A);
    send_frame(8'h2A, 1'b1);
    repeat (10) @(negedge sys_clk);
    check("single_valid_cycles", 32'(valid_cycles), 32'd1);
    check("single_no_frame_err", 32'(frame_err_cnt), 32'd0);
    check("single_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Back-to-back bytes buffered while consumer stalled
    rx_ready = 1'b0;
    exp_q.push_back(8'h2A);
    send_frame(8'h2A, 1'b1);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(8'hAB);
      send_frame(8'hAB, 1'b1);
    end
    check("b2b_cts_high", {31'd0, CTS}, 32'd1);
    check("b2b_valid", {31'd0, rx_valid}, 32'd1);
    check("b2b_head", {24'd0, rx_data}, 32'h2A);
    drain("b2b_drain");

    // Short low glitch on idle line
    @(negedge sys_clk);
    RX = 1'b0;
    repeat (2) @(negedge sys_clk);
    RX = 1'b1;
    repeat (3 * CPB) @(negedge sys_clk);
    check("glitch_no_frame_err", 32'(frame_err_cnt), 32'd0);
    check("glitch_no_valid", {31'd0, rx_valid}, 32'd0);

    // Framing error then a good frame
    fe_before = frame_err_cnt;
    valid_cycles = 0;
    send_frame(8'h55, 1'b0);
    repeat (CPB) @(negedge sys_clk);
    check("ferr_pulse_once", 32'(frame_err_cnt - fe_before), 32'd1);
    check("ferr_no_byte", 32'(valid_cycles), 32'd0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    drain("ferr_recover");

    // Fill past capacity: CTS threshold and overflow
    rx_ready = 1'b0;
    ov_before = overflow_cnt;
    for (int k = 0; k < 17; k++) begin
      b = 8'(k * 13 + 7);
      if (k < FIFO_DEPTH) exp_q.push_back(b);
      send_frame(b, 1'b1);
      if (k == CTS_THRESH - 2) check("cts_before_thresh", {31'd0, CTS}, 32'd1);
      if (k == CTS_THRESH - 1) check("cts_at_thresh", {31'd0, CTS}, 32'd0);
    end
    repeat (4) @(negedge sys_clk);
    check("overflow_pulse_once", 32'(overflow_cnt - ov_before), 32'd1);
    check("full_cts_low", {31'd0, CTS}, 32'd0);
    drain("overflow_drain");
    repeat (4) @(negedge sys_clk);
    check("cts_recovered", {31'd0, CTS}, 32'd1);

    // Reset during data bit 4, then a clean frame
    fe_before = frame_err_cnt;
    ov_before = overflow_cnt;
    b = 8'hF0;
    @(negedge sys_clk);
    RX = 1'b0;
    repeat (CPB) @(negedge sys_clk);
    for (int i = 0; i < 4; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge sys_clk);
    end
    RX = b[4];
    repeat (CPB / 2) @(negedge sys_clk);
    rst = 1'b1;
    RX = 1'b1;
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    repeat (12 * CPB) @(negedge sys_clk);
    check("midrst_no_valid", {31'd0, rx_valid}, 32'd0);
    check("midrst_no_ferr", 32'(frame_err_cnt - fe_before), 32'd0);
    check("midrst_no_overflow", 32'(overflow_cnt - ov_before), 32'd0);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    drain("midrst_recover");

`ifdef UART_RX_MAJORITY_EN
    // Single-clock spikes at the sample points are outvoted
    exp_q.push_back(8'hC3);
    send_frame_spiked(8'hC3);
    drain("majority_spike");
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
